// File: rtl/priority_value_encoder.sv
// priority_value_encoder
// Takes a one-hot or multi-hot branch-hit vector and emits the encoded value
// (bit index + 1) of each set bit, one per output handshake, in priority
// order. Vectors with more than one bit set are flagged on multi_hit for the
// whole drain. An all-zero vector gives a single-cycle zero_vec pulse and no
// output beats.
module priority_value_encoder #(
  parameter int WIDTH        = 12,
  parameter int IDXW         = 4,
  parameter bit LOWEST_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_value,
  output logic             out_last,
  output logic             multi_hit,
  output logic             zero_vec
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_mask;
  logic             one_left;
  logic             in_multi;

  // Pick the next bit to emit from pending; the last match in scan order wins.
  // NOTE: every signal gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (LOWEST_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending[i]) begin
          sel_idx     = IDXW'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending[i]) begin
          sel_idx     = IDXW'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  // Popcount tests via the clear-lowest-set-bit trick: x & (x-1) is zero
  // exactly when x has at most one bit set.
  always_comb begin
    one_left = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    in_multi = (in_vec & (in_vec - WIDTH'(1))) != '0;
  end

  // Output decode depends only on registered state, never on in_* or out_ready.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DRAIN);
    out_value = (pending != '0) ? (sel_idx + IDXW'(1)) : '0;
    out_last  = one_left;
  end

  // Accept vectors in IDLE, retire one set bit per handshake in DRAIN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      multi_hit <= 1'b0;
      zero_vec  <= 1'b0;
    end else begin
      zero_vec <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == '0) begin
              zero_vec <= 1'b1;
            end else begin
              pending   <= in_vec;
              multi_hit <= in_multi;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            pending <= pending & ~sel_mask;
            if (one_left) begin
              state     <= IDLE;
              multi_hit <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
